// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM states and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must be at least one bit wide even when a single digit is processed.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_add.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into its MSB for overflow detection.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             ci_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             co_o,
  output logic             cmsb_o
);

  logic [DIGIT:0] c;

  assign c[0] = ci_i;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign sum_o[gi] = x_i[gi] ^ y_i[gi] ^ c[gi];
    assign c[gi+1]   = (x_i[gi] & y_i[gi]) | (c[gi] & (x_i[gi] ^ y_i[gi]));
  end

  assign co_o   = c[DIGIT];
  assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: captures one operand pair, adds DIGIT bits per cycle LSB first,
// then holds the sum with carry-out and signed overflow until the consumer takes it.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, last_digit;
  int               base;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_co, dig_cmsb;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    base = int'(cnt_q) * DIGIT;
  end

  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .x_i    (a_q[base +: DIGIT]),
    .y_i    (b_q[base +: DIGIT]),
    .ci_i   (carry_q),
    .sum_o  (dig_sum),
    .co_o   (dig_co),
    .cmsb_o (dig_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so no combinational valid/ready paths exist.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      s_q     <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == RUN) begin
      s_q[base +: DIGIT] <= dig_sum;
      carry_q            <= dig_co;
      cnt_q              <= cnt_q + 1'b1;
      if (last_digit) begin
        cout_q <= dig_co;
        ovf_q  <= dig_co ^ dig_cmsb;
      end
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a 16/4 instance for the main vectors and an 8/8 one for N=1.
module tb_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] s;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  s8;

  int total = 0;
  int bad   = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for out_valid, counting rising edges since the accepting edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input vec_t v, input bit release_it);
    int n;
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " s"}, 32'(s), 32'(v.s));
    chk({name, " cout"}, 32'(cout), 32'(v.cout));
    chk({name, " ovf"}, 32'(ovf), 32'(v.ovf));
    $display("op %s: a=%h b=%h cin=%0d -> s=%h cout=%0d ovf=%0d lat=%0d",
             name, v.a, v.b, v.cin, s, cout, ovf, lat);
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, " idle"}, 32'({in_ready, out_valid}), 32'b10);
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset s", 32'(s), 32'd0);
    chk("reset cout/ovf", 32'({cout, ovf}), 32'd0);
    $display("reset: in_ready=%0d out_valid=%0d s=%h", in_ready, out_valid, s);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Backpressure: result must hold and new operands must be ignored.
    run_op("bp", vecs[0], 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp s", 32'(s), 32'h5555);
      chk("bp flags", 32'({cout, ovf}), 32'd0);
      chk("bp hs", 32'({in_ready, out_valid}), 32'b01);
      $display("bp cycle %0d: s=%h in_ready=%0d out_valid=%0d", i, s, in_ready, out_valid);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle", 32'({in_ready, out_valid}), 32'b10);
    @(negedge clk);
    chk("bp no capture", 32'(in_ready), 32'd1);

    // Reset in the second RUN cycle, then accept on the first edge after release.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst s", 32'(s), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    $display("mid-op reset: out_valid=%0d s=%h in_ready=%0d", out_valid, s, in_ready);
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post rst accept", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("post rst latency", 32'(lat), 32'd4);
    chk("post rst s", 32'(s), 32'h0002);
    $display("post-reset op: s=%h lat=%0d", s, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Degenerate single-digit instance.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; in_valid8 = 1'b1;
    chk("n1 ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    chk("n1 not yet", 32'(out_valid8), 32'd0);
    @(negedge clk);
    chk("n1 valid", 32'(out_valid8), 32'd1);
    chk("n1 s", 32'(s8), 32'h00);
    chk("n1 cout/ovf", 32'({cout8, ovf8}), 32'b11);
    $display("n1 op: a=80 b=80 -> s=%h cout=%0d ovf=%0d", s8, cout8, ovf8);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("n1 idle", 32'({in_ready8, out_valid8}), 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits added per clock cycle; SHALL satisfy 1 <= DIGIT <= WIDTH.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operands a, b and cin are presented.
REQ-006 Port in_ready  output  1  block can accept operands.
REQ-007 Port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-008 Port b  input  WIDTH  addend B.
REQ-009 Port cin  input  1  carry into bit 0.
REQ-010 Port out_valid  output  1  s, cout and ovf hold a completed result.
REQ-011 Port out_ready  input  1  consumer takes the result.
REQ-012 Port s  output  WIDTH  sum a+b+cin modulo 2^WIDTH.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready the block SHALL capture a, b and cin into registers, clear the digit counter and go to RUN.
REQ-017 RUN: each cycle the block SHALL add digit k of the captured operands plus the carry register, write the result to digit k of s, update the carry register and increment k.
REQ-018 Digits SHALL be processed LSB first; digit k covers bits [k*DIGIT +: DIGIT].
REQ-019 After the digit N-1 update the block SHALL latch cout and ovf and go to DONE; out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0; s, cout and ovf SHALL remain stable until out_valid&out_ready, then the block SHALL go to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no operand capture.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 The block SHALL accept at most one operation per N+2 cycles; there is no overlap between operations.
REQ-024 When N=1 (DIGIT=WIDTH), RUN SHALL last exactly one cycle.
REQ-025 Intermediate s digits MAY be visible during RUN; consumers SHALL sample only while out_valid=1.

Reset
REQ-026 While rst=1: state=IDLE; s=0, cout=0, ovf=0, out_valid=0; carry register, digit counter and operand registers=0; in_ready=1.
REQ-027 Reset asserted in RUN or DONE SHALL discard the operation immediately; no partial result SHALL be presented afterwards.
REQ-028 A transfer SHALL be accepted on the first rising edge after rst deasserts if in_valid=1.

Structure
REQ-029 A shared package serial_adder_pkg SHALL hold the FSM state enumeration and the N/counter-width derivation (clog2 of N, minimum 1).
REQ-030 Single sub-module digit_add (DIGIT-bit ripple adder: x, y, ci -> sum, co, carry into MSB) SHALL be instantiated once; its carry into MSB SHALL feed ovf on the last digit.
REQ-031 The RTL SHALL be synthesisable, with no latches and no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification (WIDTH=16, DIGIT=4, N=4 unless stated)
REQ-032 Basic add: a=0x1234, b=0x4321, cin=0 -> s=0x5555, cout=0, ovf=0; out_valid 4 cycles after accept.
REQ-033 Full ripple: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0.
REQ-034 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> s, cout and ovf unchanged, in_ready=0, and the new operands are not captured; IDLE follows the out_ready pulse.
REQ-036 Mid-op reset: assert rst in the 2nd RUN cycle -> out_valid=0, s=0, in_ready=1 during reset; the next operation 0x0001+0x0001 gives s=0x0002.
REQ-037 Degenerate: WIDTH=DIGIT=8, a=0x80, b=0x80, cin=0 -> s=0x00, cout=1, ovf=1; out_valid 1 cycle after accept.
